// File: rtl/fact_bcd_conv.sv
// Sequential double-dabble converter: turns a 32-bit binary value into 10 packed BCD
// digits, one bit per cycle, with valid/ready handshakes on input and output.
module fact_bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bin_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [39:0] bcd_out,
    output logic [3:0]  num_digits,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] shift_reg;
    logic [39:0] bcd;
    logic [39:0] bcd_adj;
    logic [5:0]  count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // count holds the number of iterations already completed
                if (count == 6'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction keeps every digit in 0..9 after the following left shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 10; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bcd       <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bin_in;
                        bcd       <= '0;
                        count     <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, shift_reg} <= {bcd_adj[38:0], shift_reg, 1'b0};
                    count            <= count + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = bcd;

    // Highest nonzero digit wins; an all-zero value still reports one digit
    always_comb begin
        num_digits = 4'd1;
        for (int k = 1; k < 10; k++) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                num_digits = 4'(k + 1);
            end
        end
    end

endmodule
